digit_strip_renderer: RTL and testbench

- Downstream consumer of the 5x5 digit font ROM. Turns beam position plus a latched BCD value into a scaled, on-screen strip of NUM_DIGITS glyphs.
- Each pixel clock it drives the ROM address (o_digit, o_line_num), receives the combinational 5-bit row back (i_line_pixels), and emits one 1-bit video pixel.
- Sits between the VGA sync/timing generator and the colour mux.

---
 rtl/digit_strip_renderer_pkg.sv | 13 +
 rtl/digit_strip_counters.sv | 77 +++++++
 rtl/digit_strip_renderer.sv | 83 ++++++++
 tb/tb_digit_strip_renderer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/digit_strip_renderer_pkg.sv
// digit_strip_renderer_pkg: font geometry constants, counter widths and FSM state type
package digit_strip_renderer_pkg;
  localparam int FONT_W = 5;
  localparam int FONT_H = 5;
  localparam int CELL_W = 6;
  localparam int DIGIT_W = 4;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  typedef enum logic {IDLE, ACTIVE} hstate_e;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/digit_strip_counters.sv
// digit_strip_counters: maps the beam position to glyph digit/column/row inside the strip
module digit_strip_counters
  import digit_strip_renderer_pkg::*;
#(
  parameter int X0 = 16,
  parameter int Y0 = 16,
  parameter int SCALE = 4,
  parameter int NUM_DIGITS = 4,
  parameter int POS_BITS = 10
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [POS_BITS-1:0] i_hpos,
  input  logic [POS_BITS-1:0] i_vpos,
  input  logic                i_display_on,
  output logic                o_in_strip,
  output logic [2:0]          o_dig,
  output logic [COL_W-1:0]    o_col,
  output logic [ROW_W-1:0]    o_row
);
  localparam int DW = clog2_min1(NUM_DIGITS);
  localparam int SW = clog2_min1(SCALE);
  hstate_e state_q, state_d;
  logic [DW-1:0] dig_q, dig_d, dig_c;
  logic [COL_W-1:0] col_q, col_d, col_c;
  logic [SW-1:0] sub_q, sub_d, sub_c;
  logic [ROW_W-1:0] row_q, row_d;
  logic [SW-1:0] rsub_q, rsub_d;
  logic vact_q, vact_d;
  logic start, act, run, last_sub, last_col, vstep, vfirst, vadv, rlast;
  // The start pixel is rendered in the same cycle it is detected, so the current cell is derived combinationally
  always_comb begin
    start = state_q == IDLE && i_display_on && vact_q && i_hpos == POS_BITS'(X0);
    act = i_display_on && (state_q == ACTIVE || start);
    dig_c = start ? '0 : dig_q;
    col_c = start ? '0 : col_q;
    sub_c = start ? '0 : sub_q;
    last_sub = sub_c == SW'(SCALE - 1);
    last_col = col_c == COL_W'(CELL_W - 1);
    run = act && !(last_sub && last_col && dig_c == DW'(NUM_DIGITS - 1));
    state_d = run ? ACTIVE : IDLE;
    sub_d = run && !last_sub ? sub_c + SW'(1) : '0;
    col_d = !run ? '0 : !last_sub ? col_c : last_col ? '0 : col_c + COL_W'(1);
    dig_d = !run ? '0 : last_sub && last_col ? dig_c + DW'(1) : dig_c;
    vstep = i_hpos == '0;
    rlast = rsub_q == SW'(SCALE - 1);
    vfirst = vstep && i_vpos == POS_BITS'(Y0);
    vadv = vstep && !vfirst && vact_q;
    rsub_d = vfirst ? '0 : vadv ? (rlast ? '0 : rsub_q + SW'(1)) : rsub_q;
    row_d = vfirst ? '0 : vadv && rlast ? row_q + ROW_W'(1) : row_q;
    vact_d = vfirst || (vact_q && !(vadv && rlast && row_q == ROW_W'(FONT_H - 1)));
    o_in_strip = act;
    o_dig = 3'(dig_c);
    o_col = col_c;
    o_row = row_q;
  end
  // Counter and state registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      dig_q <= '0;
      col_q <= '0;
      sub_q <= '0;
      row_q <= '0;
      rsub_q <= '0;
      vact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q <= dig_d;
      col_q <= col_d;
      sub_q <= sub_d;
      row_q <= row_d;
      rsub_q <= rsub_d;
      vact_q <= vact_d;
    end
  end
endmodule

// File: rtl/digit_strip_renderer.sv
// digit_strip_renderer: renders a scaled strip of BCD glyphs through an external 5x5 font ROM
module digit_strip_renderer
  import digit_strip_renderer_pkg::*;
#(
  parameter int X0 = 16,
  parameter int Y0 = 16,
  parameter int SCALE = 4,
  parameter int NUM_DIGITS = 4,
  parameter int POS_BITS = 10
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [POS_BITS-1:0]     i_hpos,
  input  logic [POS_BITS-1:0]     i_vpos,
  input  logic                    i_display_on,
  input  logic                    i_frame_start,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  output logic [DIGIT_W-1:0]      o_digit,
  output logic [ROW_W-1:0]        o_line_num,
  input  logic [FONT_W-1:0]       i_line_pixels,
  output logic                    o_pixel,
  output logic                    o_pixel_valid
);
  logic in_strip;
  logic [2:0] dig;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic [ROW_W-1:0] line_q, line_d;
  logic [COL_W-1:0] col_q, col_d;
  logic strip_q, strip_d, disp_q, disp_d, pixel_q, pixel_d, valid_q, valid_d;
  digit_strip_counters #(
    .X0(X0), .Y0(Y0), .SCALE(SCALE), .NUM_DIGITS(NUM_DIGITS), .POS_BITS(POS_BITS)
  ) u_counters (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_hpos(i_hpos),
    .i_vpos(i_vpos),
    .i_display_on(i_display_on),
    .o_in_strip(in_strip),
    .o_dig(dig),
    .o_col(col),
    .o_row(row)
  );
  // Stage 1 addresses the ROM from the frame shadow; stage 2 selects the dot from the returned row
  always_comb begin
    shadow_d = i_frame_start ? i_value : shadow_q;
    digit_d = in_strip ? DIGIT_W'(shadow_q >> (DIGIT_W * (NUM_DIGITS - 1 - int'(dig)))) : '0;
    line_d = in_strip ? row : '0;
    col_d = col;
    strip_d = in_strip;
    disp_d = i_display_on;
    pixel_d = strip_q && col_q < COL_W'(FONT_W) && i_line_pixels[COL_W'(FONT_W - 1) - col_q];
    valid_d = disp_q;
  end
  // Shadow and pipeline registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shadow_q <= '0;
      digit_q <= '0;
      line_q <= '0;
      col_q <= '0;
      strip_q <= 1'b0;
      disp_q <= 1'b0;
      pixel_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      digit_q <= digit_d;
      line_q <= line_d;
      col_q <= col_d;
      strip_q <= strip_d;
      disp_q <= disp_d;
      pixel_q <= pixel_d;
      valid_q <= valid_d;
    end
  end
  assign o_digit = digit_q;
  assign o_line_num = line_q;
  assign o_pixel = pixel_q;
  assign o_pixel_valid = valid_q;
endmodule

// File: tb/tb_digit_strip_renderer.sv
// tb_digit_strip_renderer: randomized scoreboard bench against a geometric reference model
module tb_digit_strip_renderer;
  localparam int X0 = 16;
  localparam int Y0 = 16;
  localparam int S = 4;
  localparam int N = 4;
  localparam int PB = 10;
  localparam int VW = 4 * N;
  localparam int STRIP_W = N * 6 * S;
  typedef struct packed {logic pix; logic [3:0] dig; logic [2:0] line;} exp_t;
  logic clk = 1'b0;
  logic rst, disp, fs;
  logic [PB-1:0] hpos, vpos;
  logic [VW-1:0] value;
  logic [3:0] o_digit;
  logic [2:0] o_line_num;
  logic [4:0] line_pixels;
  logic o_pixel, o_pixel_valid;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [VW-1:0] m_shadow;
  bit m_varm, m_hrun;
  logic [3:0] prev_dig;
  logic [2:0] prev_line;

  always #5 clk = ~clk;

  function automatic logic [4:0] font(input logic [3:0] d, input logic [2:0] r);
    logic [24:0] g;
    case (d)
      4'd0: g = 25'b01110_10001_10001_10001_01110;
      4'd1: g = 25'b00100_01100_00100_00100_01110;
      4'd2: g = 25'b11110_00001_01110_10000_11111;
      4'd3: g = 25'b11110_00001_00110_00001_11110;
      4'd4: g = 25'b10010_10010_11111_00010_00010;
      4'd5: g = 25'b11111_10000_11110_00001_11110;
      4'd6: g = 25'b01110_10000_11110_10001_01110;
      4'd7: g = 25'b11111_00001_00010_00100_00100;
      4'd8: g = 25'b01110_10001_01110_10001_01110;
      4'd9: g = 25'b01110_10001_01111_00001_01110;
      default: g = '0;
    endcase
    return r < 3'd5 ? g[24 - 5 * int'(r) -: 5] : 5'b0;
  endfunction

  assign line_pixels = font(o_digit, o_line_num);

  digit_strip_renderer #(.X0(X0), .Y0(Y0), .SCALE(S), .NUM_DIGITS(N), .POS_BITS(PB)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_hpos(hpos),
    .i_vpos(vpos),
    .i_display_on(disp),
    .i_frame_start(fs),
    .i_value(value),
    .o_digit(o_digit),
    .o_line_num(o_line_num),
    .i_line_pixels(line_pixels),
    .o_pixel(o_pixel),
    .o_pixel_valid(o_pixel_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: pixel from strip offset arithmetic, row from line offset, shadow loaded after use
  task automatic model(input int h, input int v, input bit d, input bit f, input bit r,
                       input logic [VW-1:0] val);
    int off, dg, cl, rw;
    bit vin, ins;
    logic [3:0] nib;
    logic [4:0] rowbits;
    exp_t e;
    if (r) begin
      m_shadow = '0;
      m_varm = 0;
      m_hrun = 0;
      if (q.size() > 0) q.delete(q.size() - 1);
      return;
    end
    if (h == 0 && v == Y0) m_varm = 1;
    rw = (v - Y0) / S;
    vin = m_varm && v >= Y0 && v < Y0 + 5 * S;
    off = h - X0;
    if (!d) m_hrun = 0;
    else if (!m_hrun && vin && h == X0) m_hrun = 1;
    ins = m_hrun && off >= 0 && off < STRIP_W;
    if (off >= STRIP_W - 1) m_hrun = 0;
    nib = 4'd0;
    e.pix = 1'b0;
    if (ins) begin
      dg = off / (6 * S);
      cl = (off / S) % 6;
      nib = 4'(m_shadow >> (4 * (N - 1 - dg)));
      rowbits = font(nib, 3'(rw));
      e.pix = cl < 5 && rowbits[4 - cl];
    end
    e.dig = nib;
    e.line = ins ? 3'(rw) : 3'd0;
    if (d) q.push_back(e);
    if (f) m_shadow = val;
  endtask

  task automatic step(input int h, input int v, input bit d, input bit f, input bit r,
                      input logic [VW-1:0] val);
    @(posedge clk);
    #1;
    hpos = PB'(h);
    vpos = PB'(v);
    disp = d;
    fs = f;
    rst = r;
    value = val;
    model(h, v, d, f, r, val);
  endtask

  task automatic line(input int v, input int fs_h, input logic [VW-1:0] fs_val,
                      input int drop_h, input int rst_h);
    bit d, rs, just_rst;
    just_rst = 0;
    for (int h = 0; h < 128; h++) begin
      d = h < 120 && !(drop_h >= 0 && h >= drop_h && h < drop_h + 30);
      rs = h == rst_h;
      step(h, v, d, h == fs_h, rs, h == fs_h ? fs_val : VW'($urandom));
      if (just_rst) begin
        check("rst_pixel", 32'(o_pixel), 0);
        check("rst_valid", 32'(o_pixel_valid), 0);
        check("rst_digit", 32'(o_digit), 0);
        check("rst_line", 32'(o_line_num), 0);
      end
      if (drop_h >= 0 && h == drop_h + 2) begin
        check("drop_pixel", 32'(o_pixel), 0);
        check("drop_valid", 32'(o_pixel_valid), 0);
      end
      just_rst = rs;
    end
  endtask

  task automatic frame(input int fs_v, input int fs_h, input logic [VW-1:0] fs_val,
                       input int drop_v, input int drop_h, input int rst_v, input int rst_h);
    for (int v = 12; v <= 38; v++)
      line(v, v == fs_v ? fs_h : -1, fs_val, v == drop_v ? drop_h : -1, v == rst_v ? rst_h : -1);
  endtask

  // Monitor: stage 1 address is held one cycle so it lines up with the stage 2 pixel it produced
  always @(negedge clk) begin
    exp_t e;
    if (o_pixel_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL pixel_stream: got valid 1 with no pending position, expected valid 0");
      end else begin
        e = q.pop_front();
        if (o_pixel !== e.pix || prev_dig !== e.dig || prev_line !== e.line) begin
          errors++;
          $display("FAIL pixel_stream: got pix=%0b dig=%0d line=%0d expected pix=%0b dig=%0d line=%0d",
                   o_pixel, prev_dig, prev_line, e.pix, e.dig, e.line);
        end
      end
    end
    prev_dig = o_digit;
    prev_line = o_line_num;
  end

  initial begin
    rst = 1'b1;
    disp = 1'b0;
    fs = 1'b0;
    hpos = '0;
    vpos = '0;
    value = '0;
    m_shadow = '0;
    m_varm = 0;
    m_hrun = 0;
    repeat (3) step(0, 0, 0, 0, 1, '0);
    step(0, 0, 0, 0, 0, '0);
    check("reset_pixel", 32'(o_pixel), 0);
    check("reset_valid", 32'(o_pixel_valid), 0);
    check("reset_digit", 32'(o_digit), 0);
    check("reset_line", 32'(o_line_num), 0);
    frame(12, 5, 16'h0123, -1, -1, -1, -1);
    frame(-1, -1, '0, -1, -1, -1, -1);
    frame(37, 5, 16'h9999, -1, -1, -1, -1);
    frame(16, X0, 16'hA0B7, -1, -1, -1, -1);
    frame(-1, -1, '0, 20, 30, -1, -1);
    frame(-1, -1, '0, -1, -1, 18, 25);
    frame(-1, -1, '0, -1, -1, -1, -1);
    repeat (4) frame(int'($urandom_range(12, 38)), int'($urandom_range(0, 127)), VW'($urandom),
                     -1, -1, -1, -1);
    repeat (4) step(0, 0, 0, 0, 0, '0);
    check("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
